phold_core: RTL and testbench

// - PHOLD discrete-event simulation engine inside the CAE personality. Enabled by the dispatch FSM;

---
 rtl/phold_mc_if.sv | 47 ++++
 rtl/phold_core.sv | 236 +++++++++++++++++++++++
 tb/tb_phold_core.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/phold_mc_if.sv
// Memory-controller request/response bundle for the PHOLD engine.
// Every field is a flat packed vector with one slice per MC port; port p
// occupies bits [p*W +: W] of a W-bit-per-port field.
//   master : the engine (drives requests, consumes responses)
//   slave  : the memory controller (drives stalls and responses)
// Request  : mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
//            mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rq_stall (from slave)
// Response : mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data,
//            mc_rs_stall (from master)
interface phold_mc_if #(
   parameter int NUM_MC_PORTS    = 1,
   parameter int MC_RTNCTL_WIDTH = 32
) ();
   localparam int P = NUM_MC_PORTS;
   localparam int R = MC_RTNCTL_WIDTH;

   logic [P-1:0]      mc_rq_vld;
   logic [3*P-1:0]    mc_rq_cmd;
   logic [4*P-1:0]    mc_rq_scmd;
   logic [48*P-1:0]   mc_rq_vadr;
   logic [2*P-1:0]    mc_rq_size;
   logic [R*P-1:0]    mc_rq_rtnctl;
   logic [64*P-1:0]   mc_rq_data;
   logic [P-1:0]      mc_rq_flush;
   logic [P-1:0]      mc_rq_stall;

   logic [P-1:0]      mc_rs_vld;
   logic [3*P-1:0]    mc_rs_cmd;
   logic [4*P-1:0]    mc_rs_scmd;
   logic [R*P-1:0]    mc_rs_rtnctl;
   logic [64*P-1:0]   mc_rs_data;
   logic [P-1:0]      mc_rs_stall;

   modport master (
      output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
             mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
      input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
             mc_rs_data
   );

   modport slave (
      input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
             mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
      output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
             mc_rs_data
   );
endinterface

// File: rtl/phold_core.sv
// PHOLD discrete-event simulation engine.
// Loads NUM_LP initial event timestamps from memory, then repeatedly picks the
// smallest pending timestamp, advances it by 1 + a pseudo-random 0..15 and
// writes it back, until the global virtual time reaches END_TIME. The final
// GVT is then held on gvt with rtn_vld high until rst_n falls.
// Ports:
//   clk      clock (rising edge)
//   rst_n    asynchronous active-low reset; low also means idle
//   addr     byte base address of the NUM_LP x 8-byte timestamp array
//   gvt      current global virtual time (minimum pending timestamp)
//   rtn_vld  run complete, held until reset
//   mc       memory-controller bundle (master side); only port 0 is used
module phold_core #(
   parameter int          NUM_MC_PORTS    = 1,
   parameter int          MC_RTNCTL_WIDTH = 32,
   parameter int          NUM_LP          = 8,
   parameter logic [13:0] END_TIME        = 14'd100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [47:0] addr,
   output logic [13:0] gvt,
   output logic        rtn_vld,
   phold_mc_if.master  mc
);
   localparam int P  = NUM_MC_PORTS;
   localparam int R  = MC_RTNCTL_WIDTH;
   localparam int IW = $clog2(NUM_LP);
   localparam int CW = IW + 1;

   localparam logic [2:0] CMD_RD8    = 3'd1;
   localparam logic [2:0] CMD_WR8    = 3'd2;
   localparam logic [2:0] RS_RDDATA  = 3'd2;
   localparam logic [2:0] RS_WRCMP   = 3'd3;

   typedef enum logic [2:0] {
      S_LOAD_RQ,
      S_LOAD_WT,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state_reg;
   logic          rq_vld_reg;
   logic [2:0]    rq_cmd_reg;
   logic [47:0]   rq_vadr_reg;
   logic [IW-1:0] rq_tag_reg;
   logic [13:0]   rq_data_reg;
   logic [CW-1:0] ld_cnt_reg;
   logic [CW-1:0] rs_cnt_reg;
   logic [7:0]    wr_out_reg;
   logic [13:0]   gvt_reg;
   logic          rtn_vld_reg;
   logic [15:0]   lfsr_reg;
   logic [13:0]   ts_reg [NUM_LP];

   // ---------------- combinational helpers ----------------
   logic          rq_accept;
   logic          rs_rd;
   logic          rs_wc;
   logic          load_wr;
   logic          wr_acc;
   logic [IW-1:0] rs_tag;
   logic [13:0]   rs_ts;
   logic [13:0]   min_ts;
   logic [IW-1:0] min_idx;
   logic [14:0]   new_sum;
   logic [13:0]   new_ts;
   logic [15:0]   lfsr_next;
   logic [IW-1:0] ld_idx;
   logic [47:0]   ld_addr;
   logic [47:0]   ev_addr;

   assign rq_accept = rq_vld_reg & ~mc.mc_rq_stall[0];
   assign wr_acc    = rq_accept && (rq_cmd_reg == CMD_WR8);
   assign rs_rd     = mc.mc_rs_vld[0] && (mc.mc_rs_cmd[2:0] == RS_RDDATA);
   assign rs_wc     = mc.mc_rs_vld[0] && (mc.mc_rs_cmd[2:0] == RS_WRCMP);
   assign rs_tag    = mc.mc_rs_rtnctl[IW-1:0];
   assign rs_ts     = mc.mc_rs_data[13:0];
   // Read data is only meaningful while the table is being loaded.
   assign load_wr   = rs_rd && ((state_reg == S_LOAD_RQ) || (state_reg == S_LOAD_WT));

   // Minimum search; strict less-than keeps the lowest index on ties.
   always_comb begin
      min_ts  = ts_reg[0];
      min_idx = '0;
      for (int i = 1; i < NUM_LP; i++) begin
         if (ts_reg[i] < min_ts) begin
            min_ts  = ts_reg[i];
            min_idx = IW'(i);
         end
      end
   end

   assign new_sum   = {1'b0, min_ts} + 15'd1 + {11'd0, lfsr_reg[3:0]};
   assign new_ts    = new_sum[14] ? 14'h3FFF : new_sum[13:0];
   // Fibonacci LFSR, taps 16,14,13,11, feedback enters at bit 0.
   assign lfsr_next = {lfsr_reg[14:0],
                       lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
   assign ld_idx    = ld_cnt_reg[IW-1:0];
   assign ld_addr   = addr + 48'({ld_idx, 3'b000});
   assign ev_addr   = addr + 48'({min_idx, 3'b000});

   // ---------------- control and datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_LOAD_RQ;
         rq_vld_reg  <= 1'b0;
         rq_cmd_reg  <= '0;
         rq_vadr_reg <= '0;
         rq_tag_reg  <= '0;
         rq_data_reg <= '0;
         ld_cnt_reg  <= '0;
         rs_cnt_reg  <= '0;
         wr_out_reg  <= '0;
         gvt_reg     <= '0;
         rtn_vld_reg <= 1'b0;
         lfsr_reg    <= 16'hACE1;
         for (int i = 0; i < NUM_LP; i++) begin
            ts_reg[i] <= '0;
         end
      end else begin
         // Outstanding writes: simultaneous accept and completion cancel.
         if (wr_acc && !rs_wc) begin
            wr_out_reg <= wr_out_reg + 8'd1;
         end else if (!wr_acc && rs_wc && (wr_out_reg != 8'd0)) begin
            wr_out_reg <= wr_out_reg - 8'd1;
         end

         if (load_wr) begin
            ts_reg[rs_tag] <= rs_ts;
            rs_cnt_reg     <= rs_cnt_reg + CW'(1);
         end

         case (state_reg)
            S_LOAD_RQ: begin
               if (!rq_vld_reg || rq_accept) begin
                  if (ld_cnt_reg < CW'(NUM_LP)) begin
                     rq_vld_reg  <= 1'b1;
                     rq_cmd_reg  <= CMD_RD8;
                     rq_vadr_reg <= ld_addr;
                     rq_tag_reg  <= ld_idx;
                     rq_data_reg <= '0;
                     ld_cnt_reg  <= ld_cnt_reg + CW'(1);
                  end else begin
                     rq_vld_reg  <= 1'b0;
                     rq_cmd_reg  <= '0;
                     state_reg   <= S_LOAD_WT;
                  end
               end
            end

            S_LOAD_WT: begin
               if (rs_cnt_reg == CW'(NUM_LP)) begin
                  state_reg <= S_RUN;
               end
            end

            S_RUN: begin
               gvt_reg <= min_ts;
               if (min_ts >= END_TIME) begin
                  // A still-stalled final write is finished off in DRAIN.
                  if (rq_accept) begin
                     rq_vld_reg <= 1'b0;
                     rq_cmd_reg <= '0;
                  end
                  state_reg <= S_DRAIN;
               end else if (!rq_vld_reg || rq_accept) begin
                  ts_reg[min_idx] <= new_ts;
                  rq_vld_reg      <= 1'b1;
                  rq_cmd_reg      <= CMD_WR8;
                  rq_vadr_reg     <= ev_addr;
                  rq_tag_reg      <= min_idx;
                  rq_data_reg     <= new_ts;
                  lfsr_reg        <= lfsr_next;
               end
            end

            S_DRAIN: begin
               gvt_reg <= min_ts;
               if (rq_accept) begin
                  rq_vld_reg <= 1'b0;
                  rq_cmd_reg <= '0;
               end
               if (!rq_vld_reg && (wr_out_reg == 8'd0)) begin
                  state_reg   <= S_DONE;
                  rtn_vld_reg <= 1'b1;
               end
            end

            S_DONE: begin
               rtn_vld_reg <= 1'b1;
            end

            default: begin
               state_reg <= S_LOAD_RQ;
            end
         endcase
      end
   end

   assign gvt     = gvt_reg;
   assign rtn_vld = rtn_vld_reg;

   // ---------------- port fan-out: port 0 active, others tied off ----------------
   for (genvar gi = 0; gi < P; gi++) begin : g_port
      if (gi == 0) begin : g_active
         assign mc.mc_rq_vld[gi]           = rq_vld_reg;
         assign mc.mc_rq_cmd[gi*3 +: 3]    = rq_cmd_reg;
         assign mc.mc_rq_scmd[gi*4 +: 4]   = 4'd0;
         assign mc.mc_rq_vadr[gi*48 +: 48] = rq_vadr_reg;
         // Size reads 0 while idle so the whole request bus is quiet in reset.
         assign mc.mc_rq_size[gi*2 +: 2]   = {2{rq_vld_reg}};
         assign mc.mc_rq_rtnctl[gi*R +: R] = R'(rq_tag_reg);
         assign mc.mc_rq_data[gi*64 +: 64] = {50'd0, rq_data_reg};
         assign mc.mc_rq_flush[gi]         = 1'b0;
         assign mc.mc_rs_stall[gi]         = 1'b0;
      end else begin : g_idle
         assign mc.mc_rq_vld[gi]           = 1'b0;
         assign mc.mc_rq_cmd[gi*3 +: 3]    = 3'd0;
         assign mc.mc_rq_scmd[gi*4 +: 4]   = 4'd0;
         assign mc.mc_rq_vadr[gi*48 +: 48] = 48'd0;
         assign mc.mc_rq_size[gi*2 +: 2]   = 2'd0;
         assign mc.mc_rq_rtnctl[gi*R +: R] = '0;
         assign mc.mc_rq_data[gi*64 +: 64] = 64'd0;
         assign mc.mc_rq_flush[gi]         = 1'b0;
         assign mc.mc_rs_stall[gi]         = 1'b0;
      end
   end

   // Response fields that carry no information for this engine.
   logic unused_rs;
   assign unused_rs = ^{mc.mc_rs_scmd, mc.mc_rs_data, mc.mc_rs_rtnctl,
                        mc.mc_rs_vld, mc.mc_rs_cmd, mc.mc_rq_stall};
endmodule

// File: tb/tb_phold_core.sv
module tb_phold_core;
   localparam int NLP = 8;

   logic        clk;
   logic        rst_n;
   logic [47:0] addr;
   logic [13:0] gvt;
   logic        rtn_vld;

   phold_mc_if #(.NUM_MC_PORTS(1), .MC_RTNCTL_WIDTH(32)) mc_bus ();

   phold_core #(
      .NUM_MC_PORTS(1), .MC_RTNCTL_WIDTH(32), .NUM_LP(NLP), .END_TIME(14'd100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .gvt(gvt), .rtn_vld(rtn_vld),
      .mc(mc_bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // memory image (not updated by writes, so a reload sees the initial table)
   logic [13:0] mem_ts [NLP];

   // reference model output
   logic [47:0] exp_adr [$];
   logic [13:0] exp_dat [$];
   int          exp_tag [$];
   logic [13:0] exp_gvt;

   // responder configuration and state
   int          cfg_rev, cfg_dly, cfg_stall_at;
   int          cyc;
   int          n_rd_seen, n_wr_seen, tb_out, stall_left, stall_hits;
   bit          mono_bad, early_bad, have_snap;
   logic [47:0] snap_adr;
   logic [63:0] snap_dat;
   logic [13:0] prev_gvt;
   logic [47:0] wlog_adr [$];
   logic [13:0] wlog_dat [$];
   int          rd_q [$];
   int          wr_rdy [$];
   int          wr_tag [$];

   task automatic build_model();
      logic [13:0] t [NLP];
      logic [15:0] lf;
      int          m;
      int          s;
      for (int i = 0; i < NLP; i++) t[i] = mem_ts[i];
      lf = 16'hACE1;
      exp_adr.delete(); exp_dat.delete(); exp_tag.delete();
      for (int it = 0; it < 20000; it++) begin
         m = 0;
         for (int i = 1; i < NLP; i++) if (t[i] < t[m]) m = i;
         if (t[m] >= 14'd100) break;
         s = int'(t[m]) + 1 + int'(lf[3:0]);
         if (s > 16383) s = 16383;
         exp_adr.push_back(addr + 48'(8 * m));
         exp_dat.push_back(14'(s));
         exp_tag.push_back(m);
         t[m] = 14'(s);
         lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
      end
      m = 0;
      for (int i = 1; i < NLP; i++) if (t[i] < t[m]) m = i;
      exp_gvt = t[m];
   endtask

   // Memory-controller responder: samples and drives on the falling edge.
   initial begin : responder
      int t;
      bit stall_now;
      mc_bus.mc_rq_stall  = '0;
      mc_bus.mc_rs_vld    = '0;
      mc_bus.mc_rs_cmd    = '0;
      mc_bus.mc_rs_scmd   = '0;
      mc_bus.mc_rs_rtnctl = '0;
      mc_bus.mc_rs_data   = '0;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         mc_bus.mc_rs_vld    = 1'b0;
         mc_bus.mc_rs_cmd    = 3'd0;
         mc_bus.mc_rs_rtnctl = '0;
         mc_bus.mc_rs_data   = '0;
         if (!rst_n) begin
            rd_q.delete(); wr_rdy.delete(); wr_tag.delete();
            wlog_adr.delete(); wlog_dat.delete();
            n_rd_seen = 0; n_wr_seen = 0; tb_out = 0;
            stall_left = 0; stall_hits = 0; have_snap = 0;
            mono_bad = 0; early_bad = 0; prev_gvt = '0;
            mc_bus.mc_rq_stall = 1'b0;
            continue;
         end
         if (rtn_vld && tb_out != 0) early_bad = 1;
         if (gvt < prev_gvt) mono_bad = 1;
         prev_gvt = gvt;

         stall_now = (stall_left > 0);
         if (stall_now) stall_left--;
         mc_bus.mc_rq_stall = stall_now;
         if (stall_now && mc_bus.mc_rq_vld[0]) begin
            stall_hits++;
            if (have_snap) begin
               check_eq("stall_adr", mc_bus.mc_rq_vadr, snap_adr);
               check_eq("stall_dat", mc_bus.mc_rq_data, snap_dat);
            end
            have_snap = 1;
            snap_adr  = mc_bus.mc_rq_vadr;
            snap_dat  = mc_bus.mc_rq_data;
         end else begin
            have_snap = 0;
         end

         // responses for requests accepted on earlier cycles
         if (rd_q.size() > 0 && (cfg_rev == 0 || n_rd_seen == NLP)) begin
            t = (cfg_rev != 0) ? rd_q.pop_back() : rd_q.pop_front();
            mc_bus.mc_rs_vld    = 1'b1;
            mc_bus.mc_rs_cmd    = 3'd2;
            mc_bus.mc_rs_rtnctl = 32'(t);
            mc_bus.mc_rs_data   = {18'h2A5A5, 32'hDEADBEEF, mem_ts[t]};
         end else if (wr_rdy.size() > 0 && wr_rdy[0] <= cyc) begin
            void'(wr_rdy.pop_front());
            t = wr_tag.pop_front();
            mc_bus.mc_rs_vld    = 1'b1;
            mc_bus.mc_rs_cmd    = 3'd3;
            mc_bus.mc_rs_rtnctl = 32'(t);
            tb_out--;
         end else if (cyc % 7 == 0) begin
            // unknown response command, must have no effect
            mc_bus.mc_rs_vld    = 1'b1;
            mc_bus.mc_rs_cmd    = 3'd5;
            mc_bus.mc_rs_rtnctl = 32'(cyc % NLP);
            mc_bus.mc_rs_data   = 64'd3;
         end

         // request acceptance at the coming rising edge
         if (mc_bus.mc_rq_vld[0] && !stall_now) begin
            if (mc_bus.mc_rq_cmd == 3'd1) begin
               check_eq("rd_adr", mc_bus.mc_rq_vadr, addr + 48'(8 * n_rd_seen));
               check_eq("rd_tag", mc_bus.mc_rq_rtnctl, 64'(n_rd_seen));
               rd_q.push_back(int'(mc_bus.mc_rq_rtnctl[2:0]));
               n_rd_seen++;
            end else if (mc_bus.mc_rq_cmd == 3'd2) begin
               if (n_wr_seen < exp_adr.size()) begin
                  check_eq("wr_adr", mc_bus.mc_rq_vadr, exp_adr[n_wr_seen]);
                  check_eq("wr_dat", mc_bus.mc_rq_data, {50'd0, exp_dat[n_wr_seen]});
                  check_eq("wr_tag", mc_bus.mc_rq_rtnctl, 64'(exp_tag[n_wr_seen]));
               end else begin
                  check_eq("wr_extra", 64'(n_wr_seen), 64'(exp_adr.size()));
               end
               wlog_adr.push_back(mc_bus.mc_rq_vadr);
               wlog_dat.push_back(mc_bus.mc_rq_data[13:0]);
               wr_rdy.push_back(cyc + cfg_dly);
               wr_tag.push_back(int'(mc_bus.mc_rq_rtnctl[2:0]));
               tb_out++;
               n_wr_seen++;
               if (n_wr_seen == cfg_stall_at) stall_left = 5;
            end else begin
               check_eq("rq_cmd", 64'(mc_bus.mc_rq_cmd), 64'd2);
            end
         end
      end
   end

   task automatic run_case(input string name, input int rev, input int dly,
                           input int stall_at, input int abort_at);
      build_model();
      cfg_rev = rev; cfg_dly = dly; cfg_stall_at = stall_at;
      @(negedge clk); #2;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_gvt", 64'(gvt), 64'd0);
      check_eq("rst_rtn", 64'(rtn_vld), 64'd0);
      check_eq("rst_rqvld", 64'(mc_bus.mc_rq_vld), 64'd0);
      #1;
      rst_n = 1'b1;

      if (abort_at > 0) begin
         for (int c = 0; c < 3000 && n_wr_seen < abort_at; c++) @(negedge clk);
         check_eq("abort_reach", 64'(n_wr_seen >= abort_at), 64'd1);
         #2;
         rst_n = 1'b0;
         #1;
         check_eq("abort_gvt", 64'(gvt), 64'd0);
         check_eq("abort_rqvld", 64'(mc_bus.mc_rq_vld), 64'd0);
         check_eq("abort_vadr", mc_bus.mc_rq_vadr, 64'd0);
         check_eq("abort_data", mc_bus.mc_rq_data, 64'd0);
         repeat (3) @(negedge clk);
         #2;
         rst_n = 1'b1;
      end

      for (int c = 0; c < 5000 && !rtn_vld; c++) @(negedge clk);
      check_eq("done", 64'(rtn_vld), 64'd1);
      repeat (3) @(negedge clk);
      #1;
      check_eq("rtn_hold", 64'(rtn_vld), 64'd1);
      check_eq("n_rd", 64'(n_rd_seen), 64'(NLP));
      check_eq("n_wr", 64'(n_wr_seen), 64'(exp_adr.size()));
      check_eq("gvt_final", 64'(gvt), 64'(exp_gvt));
      check_eq("gvt_mono", 64'(mono_bad), 64'd0);
      check_eq("early_rtn", 64'(early_bad), 64'd0);
      check_eq("outstanding", 64'(tb_out), 64'd0);
      check_eq("rq_idle", 64'(mc_bus.mc_rq_vld), 64'd0);
      if (exp_adr.size() > 0)
         check_eq("gvt_range", 64'(gvt >= 14'd100 && gvt <= 14'd115), 64'd1);
      if (stall_at > 0)
         check_eq("stall_cycles", 64'(stall_hits), 64'd5);
      $display("[TB] case %s: %0d reads, %0d writes, gvt=%0d", name, n_rd_seen, n_wr_seen, gvt);
   endtask

   initial begin
      rst_n = 1'b0;
      addr  = 48'h1000;
      cfg_rev = 0; cfg_dly = 1; cfg_stall_at = 0;

      for (int i = 0; i < NLP; i++) mem_ts[i] = 14'd200;
      run_case("all200", 0, 1, 0, 0);
      check_eq("all200_gvt", 64'(gvt), 64'd200);

      mem_ts = '{14'd0, 14'd50, 14'd60, 14'd70, 14'd80, 14'd90, 14'd95, 14'd99};
      run_case("inorder", 0, 1, 0, 0);
      // first two events hand-computed: 0+1+1 = 2, then 2+1+3 = 6
      check_eq("wr0_adr", 64'(wlog_adr[0]), 64'h1000);
      check_eq("wr0_dat", 64'(wlog_dat[0]), 64'd2);
      check_eq("wr1_adr", 64'(wlog_adr[1]), 64'h1000);
      check_eq("wr1_dat", 64'(wlog_dat[1]), 64'd6);

      run_case("reverse", 1, 1, 0, 0);
      run_case("stall", 0, 1, 3, 0);
      run_case("wrdelay", 0, 20, 0, 0);
      run_case("abort", 0, 1, 0, 10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
